// File: rtl/atm_pin_entry.sv
// atm_pin_entry: keypad PIN-entry unit for the ATM controller.
//
// While en is high the block collects BCD digits from the keypad, compares the
// finished entry with the card PIN and reports the result to the control unit.
// It abandons an entry after TIMEOUT quiet cycles and locks out permanently
// (until rst) after MAX_TRIES consecutive failed entries.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   en         high while the control unit is in password entry / check
//   key_valid  one-cycle strobe qualifying key_code
//   key_code   0-9 digit, 4'hA backspace, 4'hB enter, other codes ignored
//   ref_pin    card PIN, first digit in the most significant nibble
//   sf         entry finished (level)
//   sv         PIN correct, meaningful while sf is high
//   tmo        finished entry ended by timeout
//   locked     sticky lockout
//   count      digits currently buffered
module atm_pin_entry #(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned TIMEOUT   = 1000,
  parameter int unsigned MAX_TRIES = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         key_valid,
  input  logic [3:0]                   key_code,
  input  logic [4*DIGITS-1:0]          ref_pin,
  output logic                         sf,
  output logic                         sv,
  output logic                         tmo,
  output logic                         locked,
  output logic [$clog2(DIGITS+1)-1:0]  count
);

  localparam int unsigned CntW  = $clog2(DIGITS + 1);
  localparam int unsigned FailW = $clog2(MAX_TRIES + 1);
  localparam int unsigned TmrW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [CntW-1:0]  CntFull = CntW'(DIGITS);
  localparam logic [FailW-1:0] FailMax = FailW'(MAX_TRIES);
  localparam logic [TmrW-1:0]  TmrLast = TmrW'(TIMEOUT - 1);

  localparam logic [3:0] KeyMaxDigit = 4'd9;
  localparam logic [3:0] KeyBack     = 4'hA;
  localparam logic [3:0] KeyEnter    = 4'hB;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StCheck,
    StDone
  } state_e;

  state_e                    state_q, state_d;
  logic [DIGITS-1:0][3:0]    digits_q, digits_d;
  logic [CntW-1:0]           count_q, count_d;
  logic [TmrW-1:0]           timer_q, timer_d;
  logic [FailW-1:0]          fails_q, fails_d;
  logic                      locked_q, locked_d;
  logic                      sf_q, sf_d;
  logic                      sv_q, sv_d;
  logic                      tmo_q, tmo_d;

  logic                      key_digit;
  logic                      key_back;
  logic                      key_enter;
  logic                      pin_match;
  logic [FailW-1:0]          fails_inc;
  logic                      fails_hit_max;

  assign key_digit = key_valid && (key_code <= KeyMaxDigit);
  assign key_back  = key_valid && (key_code == KeyBack);
  assign key_enter = key_valid && (key_code == KeyEnter);

  // Slot i of the buffer holds the i-th typed digit, which lines up with the
  // i-th nibble of ref_pin counted from the most significant end.
  always_comb begin
    pin_match = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (digits_q[i] != ref_pin[4*(int'(DIGITS)-1-i) +: 4]) begin
        pin_match = 1'b0;
      end
    end
  end

  // Saturating failure count; lockout triggers as soon as it reaches the limit.
  assign fails_inc     = (fails_q == FailMax) ? fails_q : fails_q + 1'b1;
  assign fails_hit_max = (fails_inc == FailMax);

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    count_d  = count_q;
    timer_d  = timer_q;
    fails_d  = fails_q;
    locked_d = locked_q;
    sv_d     = sv_q;
    tmo_d    = tmo_q;

    if (!en) begin
      // Leaving entry from any state abandons everything except the try history.
      state_d  = StIdle;
      digits_d = '0;
      count_d  = '0;
      timer_d  = '0;
      sv_d     = 1'b0;
      tmo_d    = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          digits_d = '0;
          count_d  = '0;
          timer_d  = '0;
          if (locked_q) begin
            state_d = StDone;
            sv_d    = 1'b0;
            tmo_d   = 1'b0;
          end else begin
            state_d = StCollect;
          end
        end

        StCollect: begin
          if (key_valid) begin
            // Any strobe proves the customer is still there, even if ignored.
            timer_d = '0;
            if (key_digit) begin
              if (count_q < CntFull) begin
                for (int i = 0; i < int'(DIGITS); i++) begin
                  if (count_q == CntW'(i)) begin
                    digits_d[i] = key_code;
                  end
                end
                count_d = count_q + 1'b1;
              end
            end else if (key_back) begin
              if (count_q != '0) begin
                count_d = count_q - 1'b1;
              end
            end else if (key_enter) begin
              if (count_q == CntFull) begin
                state_d = StCheck;
              end
            end
          end else if (timer_q == TmrLast) begin
            state_d  = StDone;
            tmo_d    = 1'b1;
            sv_d     = 1'b0;
            fails_d  = fails_inc;
            if (fails_hit_max) begin
              locked_d = 1'b1;
            end
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end

        StCheck: begin
          state_d = StDone;
          tmo_d   = 1'b0;
          if (pin_match) begin
            fails_d = '0;
            sv_d    = 1'b1;
          end else begin
            fails_d = fails_inc;
            sv_d    = 1'b0;
            if (fails_hit_max) begin
              locked_d = 1'b1;
            end
          end
        end

        StDone: begin
          state_d = StDone;
        end

        default: begin
          state_d = StIdle;
        end
      endcase
    end

    sf_d = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      digits_q <= '0;
      count_q  <= '0;
      timer_q  <= '0;
      fails_q  <= '0;
      locked_q <= 1'b0;
      sf_q     <= 1'b0;
      sv_q     <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      count_q  <= count_d;
      timer_q  <= timer_d;
      fails_q  <= fails_d;
      locked_q <= locked_d;
      sf_q     <= sf_d;
      sv_q     <= sv_d;
      tmo_q    <= tmo_d;
    end
  end

  assign sf     = sf_q;
  assign sv     = sv_q;
  assign tmo    = tmo_q;
  assign locked = locked_q;
  assign count  = count_q;

endmodule

// File: tb/tb_atm_pin_entry.sv
// Testbench for atm_pin_entry: directed vector table, hand-written corner
// sequences and randomized sessions, all checked against a behavioural model.
module tb_atm_pin_entry;

  localparam int DIGITS    = 4;
  localparam int TIMEOUT   = 20;
  localparam int MAX_TRIES = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic [15:0] ref_pin = 16'h1234;
  logic        sf;
  logic        sv;
  logic        tmo;
  logic        locked;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  atm_pin_entry #(
    .DIGITS    (DIGITS),
    .TIMEOUT   (TIMEOUT),
    .MAX_TRIES (MAX_TRIES)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .key_valid (key_valid),
    .key_code  (key_code),
    .ref_pin   (ref_pin),
    .sf        (sf),
    .sv        (sv),
    .tmo       (tmo),
    .locked    (locked),
    .count     (count)
  );

  // ---------------------------------------------------------------- model
  // Session described by flags plus a queue of typed digits; timeout is the
  // number of consecutive quiet cycles seen while collecting.
  bit          m_coll, m_chk, m_done, m_sv, m_tmo, m_locked;
  int          m_fails, m_quiet;
  int unsigned m_buf[$];

  task automatic model_reset();
    m_coll = 0; m_chk = 0; m_done = 0; m_sv = 0; m_tmo = 0; m_locked = 0;
    m_fails = 0; m_quiet = 0;
    m_buf.delete();
  endtask

  task automatic model_fail();
    if (m_fails < MAX_TRIES) m_fails++;
    if (m_fails == MAX_TRIES) m_locked = 1;
  endtask

  task automatic model_step(input bit e, input bit kv, input logic [3:0] kc);
    logic [15:0] typed;
    if (!e) begin
      m_coll = 0; m_chk = 0; m_done = 0; m_sv = 0; m_tmo = 0; m_quiet = 0;
      m_buf.delete();
    end else if (m_chk) begin
      typed = 16'h0;
      foreach (m_buf[i]) typed = {typed[11:0], 4'(m_buf[i])};
      m_chk  = 0;
      m_done = 1;
      m_tmo  = 0;
      if (typed == ref_pin) begin
        m_fails = 0;
        m_sv    = 1;
      end else begin
        m_sv = 0;
        model_fail();
      end
    end else if (m_coll) begin
      if (kv) begin
        m_quiet = 0;
        if (kc <= 4'd9) begin
          if (m_buf.size() < DIGITS) m_buf.push_back(32'(kc));
        end else if (kc == 4'hA) begin
          if (m_buf.size() > 0) void'(m_buf.pop_back());
        end else if (kc == 4'hB) begin
          if (m_buf.size() == DIGITS) begin
            m_coll = 0;
            m_chk  = 1;
          end
        end
      end else begin
        m_quiet++;
        if (m_quiet == TIMEOUT) begin
          m_coll = 0; m_done = 1; m_tmo = 1; m_sv = 0;
          model_fail();
        end
      end
    end else if (!m_done) begin
      if (m_locked) begin
        m_done = 1; m_sv = 0; m_tmo = 0;
      end else begin
        m_coll = 1;
      end
    end
  endtask

  function automatic logic [6:0] dut_outs();
    return {sf, sv, tmo, locked, count};
  endfunction

  function automatic logic [6:0] model_outs();
    return {m_done, m_sv, m_tmo, m_locked, 3'(m_buf.size())};
  endfunction

  // ---------------------------------------------------------------- checks
  task automatic check_vec(input string name, input logic [6:0] act, input logic [6:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got {sf,sv,tmo,locked,count}=%b expected %b", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // One clock: drive inputs, step the model at the edge, compare 1 unit later.
  task automatic cycle(input bit e, input bit kv, input logic [3:0] kc);
    en        = e;
    key_valid = kv;
    key_code  = kc;
    @(posedge clk);
    model_step(e, kv, kc);
    #1;
    check_vec("model", dut_outs(), model_outs());
    key_valid = 1'b0;
  endtask

  // Reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    en        = 1'b0;
    key_valid = 1'b0;
    #2 rst = 1'b1;
    #2;
    model_reset();
    check_vec("rst_async", dut_outs(), 7'b0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Full entry of pin followed by enter; leaves the DUT in DONE with en high.
  task automatic session(input logic [15:0] pin);
    cycle(1, 0, 4'h0);
    for (int i = 0; i < DIGITS; i++) cycle(1, 1, pin[4*(3-i) +: 4]);
    cycle(1, 1, 4'hB);
    cycle(1, 0, 4'h0);
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    bit         e;
    bit         kv;
    logic [3:0] kc;
    logic [6:0] exp;   // {sf, sv, tmo, locked, count}
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit e, input bit kv, input logic [3:0] kc,
                     input bit s_f, input bit s_v, input logic [2:0] cnt);
    vec_t v;
    v.e = e; v.kv = kv; v.kc = kc;
    v.exp = {s_f, s_v, 1'b0, 1'b0, cnt};
    vecs.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] keys[$];
    bit         correct;
    int         abort_at;
    int         gap;

    model_reset();
    ref_pin = 16'h1234;
    do_reset();

    // Basic entry, backspace, early enter, excess digit, keys outside COLLECT.
    add(0, 1, 4'h5, 0, 0, 0);
    add(1, 0, 4'h0, 0, 0, 0);
    add(1, 1, 4'h1, 0, 0, 1);
    add(1, 1, 4'h2, 0, 0, 2);
    add(1, 1, 4'h3, 0, 0, 3);
    add(1, 1, 4'h4, 0, 0, 4);
    add(1, 1, 4'hB, 0, 0, 4);
    add(1, 0, 4'h0, 1, 1, 4);
    add(0, 0, 4'h0, 0, 0, 0);
    add(1, 0, 4'h0, 0, 0, 0);
    add(1, 1, 4'h1, 0, 0, 1);
    add(1, 1, 4'h2, 0, 0, 2);
    add(1, 1, 4'h9, 0, 0, 3);
    add(1, 1, 4'hA, 0, 0, 2);
    add(1, 1, 4'h3, 0, 0, 3);
    add(1, 1, 4'h4, 0, 0, 4);
    add(1, 1, 4'hB, 0, 0, 4);
    add(1, 0, 4'h0, 1, 1, 4);
    add(0, 0, 4'h0, 0, 0, 0);
    add(1, 0, 4'h0, 0, 0, 0);
    add(1, 1, 4'hA, 0, 0, 0);
    add(1, 1, 4'h1, 0, 0, 1);
    add(1, 1, 4'h2, 0, 0, 2);
    add(1, 1, 4'hB, 0, 0, 2);
    add(1, 1, 4'hC, 0, 0, 2);
    add(1, 1, 4'h3, 0, 0, 3);
    add(1, 1, 4'h4, 0, 0, 4);
    add(1, 1, 4'h5, 0, 0, 4);
    add(1, 1, 4'hB, 0, 0, 4);
    add(1, 0, 4'h0, 1, 1, 4);
    add(1, 1, 4'h7, 1, 1, 4);
    add(0, 0, 4'h0, 0, 0, 0);

    foreach (vecs[i]) begin
      cycle(vecs[i].e, vecs[i].kv, vecs[i].kc);
      check_vec($sformatf("vec%0d", i), dut_outs(), vecs[i].exp);
    end

    // Lockout after three wrong PINs; locked session finishes one cycle after en.
    do_reset();
    for (int s = 0; s < MAX_TRIES; s++) begin
      session(16'h1111);
      check_bit($sformatf("t3_sf%0d", s), sf, 1'b1);
      check_bit($sformatf("t3_sv%0d", s), sv, 1'b0);
      check_bit($sformatf("t3_lock%0d", s), locked, s == MAX_TRIES - 1);
      cycle(0, 0, 4'h0);
    end
    cycle(1, 0, 4'h0);
    check_vec("t3_locked_entry", dut_outs(), 7'b1001000);
    cycle(1, 1, 4'h1);
    check_vec("t3_locked_key", dut_outs(), 7'b1001000);
    cycle(0, 0, 4'h0);

    // Inactivity timeout, and a key on the expiry edge restarting the timer.
    do_reset();
    cycle(1, 0, 4'h0);
    cycle(1, 1, 4'h1);
    repeat (TIMEOUT - 1) cycle(1, 0, 4'h0);
    check_bit("t4_not_yet", sf, 1'b0);
    cycle(1, 0, 4'h0);
    check_vec("t4_timeout", dut_outs(), 7'b1010001);
    cycle(0, 0, 4'h0);
    cycle(1, 0, 4'h0);
    cycle(1, 1, 4'h1);
    repeat (TIMEOUT - 1) cycle(1, 0, 4'h0);
    cycle(1, 1, 4'h2);
    check_vec("t4_key_wins", dut_outs(), 7'b0000010);
    repeat (TIMEOUT - 1) cycle(1, 0, 4'h0);
    check_bit("t4_restart_quiet", sf, 1'b0);
    cycle(1, 0, 4'h0);
    check_vec("t4_restart_tmo", dut_outs(), 7'b1010010);
    cycle(0, 0, 4'h0);

    // A correct PIN clears the failure history.
    do_reset();
    repeat (2) begin
      session(16'h9999);
      cycle(0, 0, 4'h0);
    end
    session(16'h1234);
    check_bit("t5_sv", sv, 1'b1);
    cycle(0, 0, 4'h0);
    repeat (2) begin
      session(16'h4321);
      check_bit("t5_wrong_sv", sv, 1'b0);
      check_bit("t5_not_locked", locked, 1'b0);
      cycle(0, 0, 4'h0);
    end

    // en dropped during CHECK counts nothing; rst clears lockout and entry.
    do_reset();
    repeat (2) begin
      session(16'h1111);
      cycle(0, 0, 4'h0);
    end
    cycle(1, 0, 4'h0);
    for (int i = 0; i < DIGITS; i++) cycle(1, 1, 4'h1);
    cycle(1, 1, 4'hB);
    cycle(0, 0, 4'h0);
    check_vec("t6_abort", dut_outs(), 7'b0);
    cycle(1, 0, 4'h0);
    check_vec("t6_still_open", dut_outs(), 7'b0);
    for (int i = 0; i < DIGITS; i++) cycle(1, 1, 4'h1);
    cycle(1, 1, 4'hB);
    cycle(1, 0, 4'h0);
    check_vec("t6_third_locks", dut_outs(), 7'b1001100);
    do_reset();
    cycle(1, 0, 4'h0);
    check_bit("t6_unlocked_sf", sf, 1'b0);
    cycle(1, 1, 4'h1);
    cycle(1, 1, 4'h2);
    check_vec("t6_mid_entry", dut_outs(), 7'b0000010);
    do_reset();

    // Randomized sessions against the model.
    for (int s = 0; s < 60; s++) begin
      if (s % 8 == 7) do_reset();
      for (int i = 0; i < DIGITS; i++) ref_pin[4*i +: 4] = 4'($urandom_range(0, 9));
      cycle(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 11)));
      cycle(1, 0, 4'h0);
      keys.delete();
      correct = 1'($urandom_range(0, 1));
      for (int i = 0; i < DIGITS; i++) begin
        if ($urandom_range(0, 5) == 0) begin
          keys.push_back(4'($urandom_range(0, 9)));
          keys.push_back(4'hA);
        end
        if ($urandom_range(0, 7) == 0) keys.push_back(4'hB);
        keys.push_back(correct ? ref_pin[4*(3-i) +: 4] : 4'($urandom_range(0, 9)));
      end
      if ($urandom_range(0, 5) == 0) keys.push_back(4'($urandom_range(0, 9)));
      keys.push_back(4'hB);
      abort_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 5)) : -1;
      foreach (keys[k]) begin
        if (k == abort_at) break;
        gap = ($urandom_range(0, 11) == 0) ? TIMEOUT + 1 : int'($urandom_range(0, 2));
        repeat (gap) cycle(1, 0, 4'h0);
        cycle(1, 1, keys[k]);
      end
      repeat ($urandom_range(1, 4)) cycle(1, 1'($urandom_range(0, 1)),
                                         4'($urandom_range(0, 11)));
      cycle(0, 0, 4'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
